// File: rtl/qrd_skew_pkg.sv
// qrd_skew_pkg: shared state enum and sizing helpers for the QRD input skew buffer.
// Counter width is sized for the largest supported array (BASE_DELAY=4, NUM_CH=16).
package qrd_skew_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  function automatic int max_delay(input int base, input int nch);
    return base + nch - 1;
  endfunction

  localparam int CNT_W = $clog2(max_delay(4, 16) + 1);

endpackage

// File: rtl/qrd_input_skew_buffer_delay_line.sv
// qrd_skew_delay_line: DEPTH-stage data+valid shift chain, advancing on adv.
// Ports: adv advances, din/vin load stage 0 (zero when vin=0), dout/vout = last stage.
module qrd_skew_delay_line #(
  parameter int DATA_LENGTH = 8,
  parameter int DEPTH       = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   adv,
  input  logic [DATA_LENGTH-1:0] din,
  input  logic                   vin,
  output logic [DATA_LENGTH-1:0] dout,
  output logic                   vout
);

  logic [DATA_LENGTH-1:0] d_q [DEPTH];
  logic [DEPTH-1:0]       v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
      v_q <= '0;
    end else if (adv) begin
      // bubbles enter as zero so the array sees neutral samples
      d_q[0] <= vin ? din : '0;
      v_q[0] <= vin;
      for (int i = 1; i < DEPTH; i++) begin
        d_q[i] <= d_q[i-1];
        v_q[i] <= v_q[i-1];
      end
    end
  end

  assign dout = d_q[DEPTH-1];
  assign vout = v_q[DEPTH-1];

endmodule

// File: rtl/qrd_input_skew_buffer.sv
// qrd_input_skew_buffer: staggers channel k by BASE_DELAY+k advances, delays sk by
// REF_DELAY, with valid/ready flow, full stall on !out_ready and a zero-pad drain.
// Ports: in_* upstream beat (data/ref/valid/last) + in_ready; out_ready advances;
// out_data/out_valid per channel, out_ref/out_ref_valid, busy, drain_done pulse.
// Optional SKEW_BYPASS_EN: adds bypass input (sampled in IDLE) that removes the stagger.
module qrd_input_skew_buffer
  import qrd_skew_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int NUM_CH      = 5,
  parameter int BASE_DELAY  = 1,
  parameter int REF_DELAY   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CH*DATA_LENGTH-1:0] in_data,
  input  logic [DATA_LENGTH-1:0]        in_ref,
  input  logic                          in_valid,
  input  logic                          in_last,
  output logic                          in_ready,
  input  logic                          out_ready,
  output logic [NUM_CH*DATA_LENGTH-1:0] out_data,
  output logic [NUM_CH-1:0]             out_valid,
  output logic [DATA_LENGTH-1:0]        out_ref,
  output logic                          out_ref_valid,
  output logic                          busy,
  output logic                          drain_done
`ifdef SKEW_BYPASS_EN
  ,
  input  logic                          bypass
`endif
);

  localparam logic [CNT_W-1:0] DRAIN_FULL =
    CNT_W'(max_delay(BASE_DELAY, NUM_CH));

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic [CNT_W-1:0]   drain_len;
  logic               adv;
  logic               acc;

  logic [DATA_LENGTH-1:0] sk_d [NUM_CH];
  logic [NUM_CH-1:0]      sk_v;

  assign adv        = out_ready;
  assign in_ready   = out_ready && (state_q != DRAIN);
  assign acc        = in_valid && in_ready;
  assign busy       = (state_q != IDLE);
  assign drain_done = done_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    qrd_skew_delay_line #(
      .DATA_LENGTH(DATA_LENGTH),
      .DEPTH      (BASE_DELAY + k)
    ) u_dl (
      .clk  (clk),
      .rst_n(rst_n),
      .adv  (adv),
      .din  (in_data[k*DATA_LENGTH +: DATA_LENGTH]),
      .vin  (acc),
      .dout (sk_d[k]),
      .vout (sk_v[k])
    );
  end

  qrd_skew_delay_line #(
    .DATA_LENGTH(DATA_LENGTH),
    .DEPTH      (REF_DELAY)
  ) u_ref (
    .clk  (clk),
    .rst_n(rst_n),
    .adv  (adv),
    .din  (in_ref),
    .vin  (acc),
    .dout (out_ref),
    .vout (out_ref_valid)
  );

`ifdef SKEW_BYPASS_EN
  logic                          byp_q;
  logic                          byp_now;
  logic [NUM_CH*DATA_LENGTH-1:0] byp_d;
  logic                          byp_v;

  // the beat accepted in IDLE already uses the mode being latched
  assign byp_now   = (state_q == IDLE) ? bypass : byp_q;
  assign drain_len = byp_now ? CNT_W'(BASE_DELAY) : DRAIN_FULL;

  // unstaggered chain carrying the whole vector
  qrd_skew_delay_line #(
    .DATA_LENGTH(NUM_CH*DATA_LENGTH),
    .DEPTH      (BASE_DELAY)
  ) u_byp (
    .clk  (clk),
    .rst_n(rst_n),
    .adv  (adv),
    .din  (in_data),
    .vin  (acc),
    .dout (byp_d),
    .vout (byp_v)
  );

  always_comb begin
    out_data  = '0;
    out_valid = '0;
    if (byp_q) begin
      out_data  = byp_d;
      out_valid = {NUM_CH{byp_v}};
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        out_data[k*DATA_LENGTH +: DATA_LENGTH] = sk_d[k];
        out_valid[k] = sk_v[k];
      end
    end
  end
`else
  assign drain_len = DRAIN_FULL;

  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      out_data[k*DATA_LENGTH +: DATA_LENGTH] = sk_d[k];
      out_valid[k] = sk_v[k];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef SKEW_BYPASS_EN
      byp_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SKEW_BYPASS_EN
      if (state_q == IDLE) byp_q <= bypass;
`endif
      if (adv) begin
        unique case (state_q)
          IDLE: begin
            if (acc) begin
              if (in_last) begin
                state_q <= DRAIN;
                cnt_q   <= drain_len;
              end else begin
                state_q <= RUN;
              end
            end
          end
          RUN: begin
            if (acc && in_last) begin
              state_q <= DRAIN;
              cnt_q   <= drain_len;
            end
          end
          DRAIN: begin
            if (cnt_q == CNT_W'(1)) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qrd_input_skew_buffer.sv
// tb_qrd_input_skew_buffer: scoreboard bench for the QRD input skew buffer.
// Expected beats queue per channel with their due advance; popped as outputs appear.
module tb_qrd_input_skew_buffer;

  localparam int DL  = 8;
  localparam int NCH = 5;
  localparam int BD  = 1;
  localparam int RD  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*DL-1:0] in_data;
  logic [DL-1:0]     in_ref;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              out_ready;
  logic [NCH*DL-1:0] out_data;
  logic [NCH-1:0]    out_valid;
  logic [DL-1:0]     out_ref;
  logic              out_ref_valid;
  logic              busy;
  logic              drain_done;

  always #5 clk = ~clk;

  qrd_input_skew_buffer #(
    .DATA_LENGTH(DL),
    .NUM_CH     (NCH),
    .BASE_DELAY (BD),
    .REF_DELAY  (RD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_ref       (in_ref),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ref      (out_ref),
    .out_ref_valid(out_ref_valid),
    .busy         (busy),
    .drain_done   (drain_done)
`ifdef SKEW_BYPASS_EN
    ,
    .bypass       (1'b0)
`endif
  );

  typedef struct {
    logic [DL-1:0] d;
    int            due;
  } ent_t;

  ent_t cq [NCH][$];
  ent_t rq [$];

  int total = 0;
  int bad   = 0;
  int advn  = 0;
  int drain_due = 0;
  int dd_cnt = 0;
  bit m_busy = 0;
  bit m_drain = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit v, input bit l,
                     input logic [NCH*DL-1:0] d,
                     input logic [DL-1:0] r, input bit rdy);
    bit exp_rdy;
    bit acc;
    bit dd;
    bit ev;
    ent_t e;
    logic [NCH*DL-1:0] p_d;
    logic [NCH-1:0] p_v;
    logic [DL-1:0] p_r;
    in_valid  = v;
    in_last   = l;
    in_data   = d;
    in_ref    = r;
    out_ready = rdy;
    #1;
    exp_rdy = rdy && !m_drain;
    chk("in_ready", in_ready, exp_rdy);
    acc = v && exp_rdy;
    p_d = out_data;
    p_v = out_valid;
    p_r = out_ref;
    @(posedge clk);
    #1;
    dd = 0;
    if (rdy) begin
      advn++;
      if (acc) begin
        for (int k = 0; k < NCH; k++) begin
          e.d = d[k*DL +: DL];
          e.due = advn + BD + k - 1;
          cq[k].push_back(e);
        end
        e.d = r;
        e.due = advn + RD - 1;
        rq.push_back(e);
        m_busy = 1;
        if (l) begin
          m_drain = 1;
          drain_due = advn + BD + NCH - 1;
        end
      end
      if (m_drain && advn == drain_due) begin
        dd = 1;
        m_drain = 0;
        m_busy = 0;
      end
      for (int k = 0; k < NCH; k++) begin
        ev = (cq[k].size() > 0) && (cq[k][0].due == advn);
        chk($sformatf("vld%0d", k), out_valid[k], ev);
        if (ev) begin
          e = cq[k].pop_front();
          chk($sformatf("dat%0d", k), out_data[k*DL +: DL], e.d);
        end else begin
          chk($sformatf("bub%0d", k), out_data[k*DL +: DL], 0);
        end
      end
      ev = (rq.size() > 0) && (rq[0].due == advn);
      chk("ref_vld", out_ref_valid, ev);
      if (ev) begin
        e = rq.pop_front();
        chk("ref_dat", out_ref, e.d);
      end else begin
        chk("ref_bub", out_ref, 0);
      end
    end else begin
      chk("stall_dat", out_data, p_d);
      chk("stall_vld", out_valid, p_v);
      chk("stall_ref", out_ref, p_r);
    end
    chk("busy", busy, m_busy);
    chk("drain_done", drain_done, dd);
    if (drain_done) dd_cnt++;
  endtask

  task automatic idle_wait();
    for (int i = 0; i < 30 && busy; i++) cyc(0, 0, '0, '0, 1);
    chk("idle_timeout", busy, 0);
  endtask

  function automatic logic [NCH*DL-1:0] rnd_vec();
    logic [NCH*DL-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*DL +: DL] = DL'($urandom);
    return v;
  endfunction

  initial begin
    int diag [8];
    int c0;
    logic [NCH*DL-1:0] dv;
    diag = '{1, 3, 7, 14, 28, 24, 16, 0};
    rst_n = 0;
    in_valid = 0;
    in_last = 0;
    in_data = '0;
    in_ref = '0;
    out_ready = 0;
    #12;
    chk("rst_vld", out_valid, 0);
    chk("rst_dat", out_data, 0);
    chk("rst_refv", out_ref_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", drain_done, 0);
    @(negedge clk);
    rst_n = 1;

    // basic stagger: out_valid walks the diagonal
    for (int i = 0; i < 8; i++) begin
      if (i < 3) cyc(1, i == 2, {NCH{8'(8'h10 + i)}}, 8'(8'h90 + i), 1);
      else cyc(0, 0, '0, '0, 1);
      chk($sformatf("diag%0d", i), out_valid, diag[i]);
    end
    chk("t1_idle", busy, 0);

    // stall mid-block: upstream holds beat 3 while out_ready=0
    for (int i = 0; i < 3; i++) cyc(1, 0, rnd_vec(), 8'(i), 1);
    dv = rnd_vec();
    for (int i = 0; i < 3; i++) cyc(1, 0, dv, 8'h33, 0);
    cyc(1, 0, dv, 8'h33, 1);
    cyc(1, 0, rnd_vec(), 8'h44, 1);
    cyc(1, 1, rnd_vec(), 8'h55, 1);
    idle_wait();

    // single-beat block straight into DRAIN
    c0 = dd_cnt;
    cyc(1, 1, {NCH{8'hA5}}, 8'hA5, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, rnd_vec(), 8'h00, 1);
    cyc(0, 0, '0, '0, 1);
    chk("t3_pulses", dd_cnt - c0, 1);
    chk("t3_vld", out_valid, 0);
    chk("t3_busy", busy, 0);

    // bubbles in the middle of a block
    cyc(1, 0, rnd_vec(), 8'h61, 1);
    cyc(0, 0, rnd_vec(), 8'h62, 1);
    cyc(1, 1, rnd_vec(), 8'h63, 1);
    idle_wait();

    // async reset between edges while draining
    c0 = dd_cnt;
    cyc(1, 1, rnd_vec(), 8'h77, 1);
    cyc(0, 0, '0, '0, 1);
    #3;
    rst_n = 0;
    #1;
    chk("ar_vld", out_valid, 0);
    chk("ar_dat", out_data, 0);
    chk("ar_refv", out_ref_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", drain_done, 0);
    chk("ar_rdy", in_ready, 1);
    for (int k = 0; k < NCH; k++) cq[k].delete();
    rq.delete();
    m_busy = 0;
    m_drain = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) cyc(0, 0, '0, '0, 1);
    chk("ar_nopulse", dd_cnt - c0, 0);

    // random traffic with random back-pressure
    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), 0, rnd_vec(), 8'($urandom),
          $urandom_range(0, 4) != 0);
    for (int i = 0; i < 10 && !m_drain; i++)
      cyc(1, 1, rnd_vec(), 8'hEE, 1);
    chk("rnd_last", m_drain || !m_busy, 1);
    idle_wait();
    for (int k = 0; k < NCH; k++)
      chk($sformatf("left%0d", k), cq[k].size(), 0);
    chk("left_ref", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qrd_input_skew_buffer.md
Name: qrd_input_skew_buffer

Overview:
- Parametrised input-staggering stage in front of the QRD-RLS systolic array.
- Delays channel k by BASE_DELAY+k cycles, so successive array columns receive a sample vector one cycle apart.
- Carries the reference signal sk through a fixed delay.
- Adds valid/ready flow control, stall, end-of-block zero-pad drain and per-channel valid tags, so any array size can be fed without hand-written temp registers.

Parameters:
- DATA_LENGTH, 8: sample width in bits.
- NUM_CH, 5: array channel count (boundary cell = ch0, internal cells = ch1..NUM_CH-1); range 2..16.
- BASE_DELAY, 1: delay of ch0 in advances; range 1..4.
- REF_DELAY, 1: delay of the sk path in advances; range 1..(BASE_DELAY+NUM_CH-1).

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_data, input, NUM_CH*DATA_LENGTH: sample vector; ch k occupies bits [k*DATA_LENGTH +: DATA_LENGTH].
- in_ref, input, DATA_LENGTH: reference sample sk.
- in_valid, input, 1: input beat valid.
- in_last, input, 1: marks the final beat of a block; qualified by acceptance.
- in_ready, output, 1: buffer accepts a beat this cycle.
- out_ready, input, 1: array can advance this cycle.
- out_data, output, NUM_CH*DATA_LENGTH: skewed channel outputs.
- out_valid, output, NUM_CH: per-channel valid tag.
- out_ref, output, DATA_LENGTH: delayed sk.
- out_ref_valid, output, 1: valid tag for out_ref.
- busy, output, 1: state is not IDLE.
- drain_done, output, 1: one-cycle pulse at the end of DRAIN.

Behaviour:
- Reset: rst_n low clears all of the following immediately, regardless of clk:
  - every delay stage (data and valid bit);
  - the drain counter;
  - the state (to IDLE);
  - out_data, out_valid, out_ref, out_ref_valid, busy and drain_done.
- Reset asserted mid-RUN or mid-DRAIN discards all in-flight data; no drain_done pulse is issued.
- Advance: adv = out_ready. When adv=0, every stage, the counter and the state hold (full stall).
- Acceptance:
  - in_ready = out_ready AND state != DRAIN.
  - A beat is accepted when in_valid AND in_ready.
- Stage 0 load on adv (per channel, and for the ref path):
  - accepted beat: loads the data with valid=1;
  - no accepted beat: loads zero with valid=0.
- Delay chains:
  - ch k is a chain of BASE_DELAY+k stages; out_data/out_valid for ch k are the last stage.
  - Ref is a chain of REF_DELAY stages.
- Latency: a beat accepted on advance n appears on ch k after advance n+BASE_DELAY+k-1, i.e. BASE_DELAY+k advances after acceptance. With no stalls, that is BASE_DELAY+k cycles.
- Bubbles are zero-valued with valid=0, so the array sees neutral inputs.
- FSM:
  - IDLE→RUN on the first accepted beat.
  - RUN→DRAIN on an accepted beat with in_last=1.
  - In DRAIN:
    - the counter loads BASE_DELAY+NUM_CH-1 on entry;
    - it decrements on each adv;
    - on adv when the counter is 1: state→IDLE, drain_done=1 for exactly that following cycle.
  - An accepted beat in IDLE with in_last=1 goes directly IDLE→DRAIN (single-beat block).
- DRAIN blocks input (in_ready=0) until the longest chain is flushed. Afterwards all out_valid bits are 0.
- Simultaneous events:
  - in_last accepted while out_ready=1 loads the counter that same edge.
  - in_valid while out_ready=0 is not accepted; upstream holds the beat.

Optional Feature:
- Macro: SKEW_BYPASS_EN.
- Defined:
  - adds input port bypass (1 bit);
  - bypass is sampled only while in IDLE;
  - while bypass is latched high, every channel uses BASE_DELAY stages (no stagger), and the drain length is BASE_DELAY.
- Undefined: the port is absent and the stagger is always active.

Decomposition:
- Package qrd_skew_pkg holds:
  - the state enum (IDLE, RUN, DRAIN);
  - function max_delay(BASE_DELAY, NUM_CH);
  - the counter width constant derived from max_delay.
- Sub-module qrd_skew_delay_line: one channel; parameters DATA_LENGTH and DEPTH; ports clk, rst_n, adv, din, vin, dout, vout.
  - Instantiated NUM_CH times via generate, plus once for the ref path.

Test Plan (all with NUM_CH=5, DATA_LENGTH=8, BASE_DELAY=1, REF_DELAY=1 unless noted):
1. Basic stagger: out_ready=1; send beats of all channels = 8'h10, 8'h11, 8'h12 (last on the third) → ch0 shows 8'h10 at cycle 1, ch4 shows 8'h10 at cycle 5, out_ref aligned with ch0, out_valid diagonal pattern.
2. Stall: hold out_ready=0 for 3 cycles mid-block → all outputs frozen, in_ready=0, stagger and relative timing preserved after resume.
3. Drain: single beat 8'hA5 with in_last → DRAIN for 5 advances, in_ready=0 throughout, drain_done pulses once, then all out_valid=0 and busy=0.
4. Bubbles: in_valid toggling 1,0,1 → zero/valid=0 slots appear on every channel at the matching skew.
5. Async reset: assert rst_n low mid-DRAIN between edges → outputs zero immediately, no drain_done, state IDLE.
6. SKEW_BYPASS_EN build: bypass=1 in IDLE → all five channels output the beat simultaneously after 1 cycle; drain lasts 1 advance.
